hazard3_mem_arbiter: RTL and testbench

Two-master arbiter sharing one pipelined memory port between the instruction fetch port of the frontend (I) and the load/store port (D). It sits between the core and the single memory bus. It grants address phases, holds a stalled grant stable, and tracks up to two in-flight transfers so that returned data is routed to the master that issued them. D has priority. A starvation counter guarantees fetch forward progress.

---
 rtl/hazard3_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_hazard3_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard3_mem_arbiter.sv
// hazard3_mem_arbiter: shares one pipelined memory port between instruction
// fetch (I) and load/store (D). D has priority. A starvation counter forces an
// I grant after STARVE_LIMIT consecutive D grants. A 2-deep owner FIFO routes
// returned data phases back to the master that issued them.
module hazard3_mem_arbiter #(
   parameter int unsigned W_ADDR       = 32,
   parameter int unsigned W_DATA       = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,

   input  logic [W_ADDR-1:0] i_addr,
   input  logic              i_size,
   input  logic              i_addr_vld,
   output logic              i_addr_rdy,
   output logic [W_DATA-1:0] i_data,
   output logic              i_data_vld,

   input  logic [W_ADDR-1:0] d_addr,
   input  logic [1:0]        d_size,
   input  logic              d_write,
   input  logic [W_DATA-1:0] d_wdata,
   input  logic              d_addr_vld,
   output logic              d_addr_rdy,
   output logic [W_DATA-1:0] d_rdata,
   output logic              d_data_vld,

   output logic [W_ADDR-1:0] m_addr,
   output logic [1:0]        m_size,
   output logic              m_write,
   output logic [W_DATA-1:0] m_wdata,
   output logic              m_addr_vld,
   input  logic              m_addr_rdy,
   input  logic [W_DATA-1:0] m_rdata,
   input  logic              m_data_vld
);

   localparam int unsigned W_CTR      = 4;
   localparam logic [W_CTR-1:0] STARVE_MAX = W_CTR'(STARVE_LIMIT);

   logic             grant_d_r;
   logic             hold_r;
   logic [1:0]       outstanding;
   logic [1:0]       owner_fifo;
   logic             wr_ptr;
   logic             rd_ptr;
   logic [W_CTR-1:0] starve_ctr;

   logic             gnt_i;
   logic             gnt_d;
   logic             push;
   logic             pop;
   logic             head_d;

   // Grant selection: held grant first, then in-flight limit, then I/D priority.
   // Depends only on registered state and the request valids.
   always_comb begin
      gnt_i = 1'b0;
      gnt_d = 1'b0;
      if (!rst) begin
         if (hold_r) begin
            gnt_d = grant_d_r;
            gnt_i = !grant_d_r;
         end else if (outstanding != 2'd2) begin
            if (i_addr_vld && (starve_ctr == STARVE_MAX || !d_addr_vld)) begin
               gnt_i = 1'b1;
            end else if (d_addr_vld) begin
               gnt_d = 1'b1;
            end
         end
      end
   end

   // Address-phase mux toward the bus; zero when idle.
   always_comb begin
      m_addr  = '0;
      m_size  = 2'b00;
      m_write = 1'b0;
      if (gnt_d) begin
         m_addr  = d_addr;
         m_size  = d_size;
         m_write = d_write;
      end else if (gnt_i) begin
         m_addr  = i_addr;
         m_size  = i_size ? 2'b10 : 2'b01;
      end
   end

   assign m_addr_vld = gnt_i | gnt_d;
   assign i_addr_rdy = m_addr_rdy & gnt_i;
   assign d_addr_rdy = m_addr_rdy & gnt_d;
   assign m_wdata    = d_wdata;

   // Data-phase routing: a return with nothing in flight is dropped.
   assign push       = m_addr_vld & m_addr_rdy;
   assign pop        = m_data_vld & (outstanding != 2'd0) & !rst;
   assign head_d     = owner_fifo[rd_ptr];
   assign i_data_vld = pop & !head_d;
   assign d_data_vld = pop & head_d;
   assign i_data     = m_rdata;
   assign d_rdata    = m_rdata;

   // Grant hold, owner FIFO, in-flight count and starvation counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_d_r   <= 1'b0;
         hold_r      <= 1'b0;
         outstanding <= 2'd0;
         owner_fifo  <= 2'b00;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         starve_ctr  <= '0;
      end else begin
         hold_r <= m_addr_vld & !m_addr_rdy;
         if (m_addr_vld) begin
            grant_d_r <= gnt_d;
         end
         if (push) begin
            owner_fifo[wr_ptr] <= gnt_d;
            wr_ptr             <= !wr_ptr;
         end
         if (pop) begin
            rd_ptr <= !rd_ptr;
         end
         case ({push, pop})
            2'b10:   outstanding <= outstanding + 2'd1;
            2'b01:   outstanding <= outstanding - 2'd1;
            default: outstanding <= outstanding;
         endcase
         if (!i_addr_vld || (push && gnt_i)) begin
            starve_ctr <= '0;
         end else if (push && gnt_d && starve_ctr != STARVE_MAX) begin
            starve_ctr <= starve_ctr + W_CTR'(1);
         end
      end
   end

endmodule

// File: tb/tb_hazard3_mem_arbiter.sv
// Self-checking bench for hazard3_mem_arbiter: directed bus scenarios with a
// scoreboard of expected grant owners and expected data-return owners.
module tb_hazard3_mem_arbiter;

   logic        clk;
   logic        rst;
   logic [31:0] i_addr;
   logic        i_size;
   logic        i_addr_vld;
   logic        i_addr_rdy;
   logic [31:0] i_data;
   logic        i_data_vld;
   logic [31:0] d_addr;
   logic [1:0]  d_size;
   logic        d_write;
   logic [31:0] d_wdata;
   logic        d_addr_vld;
   logic        d_addr_rdy;
   logic [31:0] d_rdata;
   logic        d_data_vld;
   logic [31:0] m_addr;
   logic [1:0]  m_size;
   logic        m_write;
   logic [31:0] m_wdata;
   logic        m_addr_vld;
   logic        m_addr_rdy;
   logic [31:0] m_rdata;
   logic        m_data_vld;

   int n_checks = 0;
   int n_errors = 0;

   // expected owner of each accepted address (1 = D), and of each data return
   bit exp_grant_q[$];
   bit ret_q[$];

   hazard3_mem_arbiter #(.W_ADDR(32), .W_DATA(32), .STARVE_LIMIT(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_addr     (i_addr),
      .i_size     (i_size),
      .i_addr_vld (i_addr_vld),
      .i_addr_rdy (i_addr_rdy),
      .i_data     (i_data),
      .i_data_vld (i_data_vld),
      .d_addr     (d_addr),
      .d_size     (d_size),
      .d_write    (d_write),
      .d_wdata    (d_wdata),
      .d_addr_vld (d_addr_vld),
      .d_addr_rdy (d_addr_rdy),
      .d_rdata    (d_rdata),
      .d_data_vld (d_data_vld),
      .m_addr     (m_addr),
      .m_size     (m_size),
      .m_write    (m_write),
      .m_wdata    (m_wdata),
      .m_addr_vld (m_addr_vld),
      .m_addr_rdy (m_addr_rdy),
      .m_rdata    (m_rdata),
      .m_data_vld (m_data_vld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: data returns are checked before new grants are pushed.
   always @(negedge clk) begin
      if (!rst) begin
         if (m_data_vld) begin
            if (ret_q.size() > 0) begin
               bit o;
               o = ret_q.pop_front();
               check("ret_i_vld", 32'(i_data_vld), 32'(!o));
               check("ret_d_vld", 32'(d_data_vld), 32'(o));
               check("ret_data", o ? d_rdata : i_data, m_rdata);
            end else begin
               $display("note: m_data_vld with nothing in flight (protocol error), ignored");
               check("spur_vld", {30'd0, i_data_vld, d_data_vld}, 32'd0);
            end
         end else begin
            check("idle_ret", {30'd0, i_data_vld, d_data_vld}, 32'd0);
         end
         if (m_addr_vld && m_addr_rdy) begin
            if (exp_grant_q.size() == 0) begin
               check("grant_unexp", 32'd1, 32'd0);
            end else begin
               bit e;
               logic [1:0] esz;
               e   = exp_grant_q.pop_front();
               esz = e ? d_size : (i_size ? 2'b10 : 2'b01);
               check("grant_d", 32'(d_addr_rdy), 32'(e));
               check("grant_i", 32'(i_addr_rdy), 32'(!e));
               check("m_addr", m_addr, e ? d_addr : i_addr);
               check("m_size", 32'(m_size), 32'(esz));
               check("m_write", 32'(m_write), e ? 32'(d_write) : 32'd0);
               ret_q.push_back(e);
            end
         end else begin
            check("no_accept", {30'd0, i_addr_rdy, d_addr_rdy}, 32'd0);
         end
      end
   end

   initial begin
      rst = 1'b1;
      i_addr = 32'h100; i_size = 1'b1; i_addr_vld = 1'b1;
      d_addr = '0; d_size = 2'd2; d_write = 1'b0; d_wdata = '0; d_addr_vld = 1'b0;
      m_addr_rdy = 1'b1; m_rdata = '0; m_data_vld = 1'b1;

      // reset with a request and a spurious return present
      @(negedge clk);
      check("rst_m_addr_vld", 32'(m_addr_vld), 32'd0);
      check("rst_i_addr_rdy", 32'(i_addr_rdy), 32'd0);
      check("rst_d_addr_rdy", 32'(d_addr_rdy), 32'd0);
      check("rst_i_data_vld", 32'(i_data_vld), 32'd0);
      check("rst_d_data_vld", 32'(d_data_vld), 32'd0);
      cyc(); cyc();
      rst = 1'b0; i_addr_vld = 1'b0;
      @(negedge clk);
      check("post_rst_spur", {30'd0, i_data_vld, d_data_vld}, 32'd0);
      cyc();
      m_data_vld = 1'b0;

      // idle to single fetch transfer
      i_addr = 32'h100; i_size = 1'b1; i_addr_vld = 1'b1; m_addr_rdy = 1'b1;
      exp_grant_q.push_back(1'b0);
      @(negedge clk);
      check("single_m_addr", m_addr, 32'h100);
      check("single_i_rdy", 32'(i_addr_rdy), 32'd1);
      check("single_m_size", 32'(m_size), 32'd2);
      cyc();
      i_addr_vld = 1'b0; m_data_vld = 1'b1; m_rdata = 32'hCAFE_0001;
      @(negedge clk);
      check("single_i_data_vld", 32'(i_data_vld), 32'd1);
      check("single_d_data_vld", 32'(d_data_vld), 32'd0);
      check("idle_m_addr_vld", 32'(m_addr_vld), 32'd0);
      check("idle_m_addr", m_addr, 32'd0);
      cyc();
      m_data_vld = 1'b0;

      // priority with starvation limit: D,D,D,D,I repeating
      i_addr = 32'h1000; i_size = 1'b0; d_addr = 32'h2000; d_size = 2'd1;
      i_addr_vld = 1'b1; d_addr_vld = 1'b1; m_addr_rdy = 1'b1;
      for (int k = 0; k < 10; k++) begin
         exp_grant_q.push_back((k % 5) != 4);
         m_data_vld = (k > 0);
         m_rdata = 32'h5000 + 32'(k);
         cyc();
      end
      i_addr_vld = 1'b0; d_addr_vld = 1'b0; m_data_vld = 1'b1; m_rdata = 32'h5100;
      cyc();
      m_data_vld = 1'b0;

      // stall hold: I stalled 3 cycles, D arrives on the second
      m_addr_rdy = 1'b0; i_addr = 32'h200; i_size = 1'b1; i_addr_vld = 1'b1;
      @(negedge clk);
      check("stall1_m_addr", m_addr, 32'h200);
      check("stall1_vld", 32'(m_addr_vld), 32'd1);
      cyc();
      d_addr = 32'h300; d_size = 2'd2; d_addr_vld = 1'b1;
      @(negedge clk);
      check("stall2_m_addr", m_addr, 32'h200);
      check("stall2_d_rdy", 32'(d_addr_rdy), 32'd0);
      cyc();
      @(negedge clk);
      check("stall3_m_addr", m_addr, 32'h200);
      cyc();
      m_addr_rdy = 1'b1;
      exp_grant_q.push_back(1'b0);
      @(negedge clk);
      check("stall_accept_m_addr", m_addr, 32'h200);
      cyc();
      i_addr_vld = 1'b0;
      exp_grant_q.push_back(1'b1);
      @(negedge clk);
      check("after_stall_m_addr", m_addr, 32'h300);
      cyc();
      d_addr_vld = 1'b0; m_data_vld = 1'b1; m_rdata = 32'h6001;
      cyc();
      m_rdata = 32'h6002;
      cyc();
      m_data_vld = 1'b0;

      // outstanding limit of two
      i_addr = 32'h400; i_size = 1'b0; i_addr_vld = 1'b1;
      exp_grant_q.push_back(1'b0);
      cyc();
      i_addr_vld = 1'b0; d_addr = 32'h500; d_write = 1'b1; d_wdata = 32'hDEAD_BEEF; d_addr_vld = 1'b1;
      exp_grant_q.push_back(1'b1);
      @(negedge clk);
      check("lim_m_write", 32'(m_write), 32'd1);
      check("lim_m_wdata", m_wdata, 32'hDEAD_BEEF);
      cyc();
      d_addr_vld = 1'b0; i_addr = 32'h404; i_addr_vld = 1'b1;
      @(negedge clk);
      check("lim_full_vld", 32'(m_addr_vld), 32'd0);
      check("lim_full_i_rdy", 32'(i_addr_rdy), 32'd0);
      cyc();
      m_data_vld = 1'b1; m_rdata = 32'h7001;
      @(negedge clk);
      check("lim_ret1_i", 32'(i_data_vld), 32'd1);
      check("lim_ret1_vld", 32'(m_addr_vld), 32'd0);
      cyc();
      m_rdata = 32'h7002;
      exp_grant_q.push_back(1'b0);
      @(negedge clk);
      check("lim_ret2_d", 32'(d_data_vld), 32'd1);
      check("lim_regrant_addr", m_addr, 32'h404);
      cyc();
      i_addr_vld = 1'b0; m_rdata = 32'h7003;
      cyc();
      m_data_vld = 1'b0; d_write = 1'b0;

      // simultaneous push and pop at one in flight, then a spurious return
      d_addr = 32'h600; d_addr_vld = 1'b1;
      exp_grant_q.push_back(1'b1);
      cyc();
      d_addr_vld = 1'b0; i_addr = 32'h700; i_addr_vld = 1'b1; m_data_vld = 1'b1; m_rdata = 32'h8001;
      exp_grant_q.push_back(1'b0);
      @(negedge clk);
      check("pp_d_ret", 32'(d_data_vld), 32'd1);
      check("pp_i_rdy", 32'(i_addr_rdy), 32'd1);
      cyc();
      i_addr_vld = 1'b0; m_rdata = 32'h8002;
      @(negedge clk);
      check("pp_i_ret", 32'(i_data_vld), 32'd1);
      cyc();
      m_rdata = 32'h8003;
      @(negedge clk);
      check("pp_spur", {30'd0, i_data_vld, d_data_vld}, 32'd0);
      cyc();
      m_data_vld = 1'b0;

      // reset with two in flight
      i_addr = 32'h800; i_addr_vld = 1'b1;
      exp_grant_q.push_back(1'b0);
      cyc();
      i_addr_vld = 1'b0; d_addr = 32'h900; d_addr_vld = 1'b1;
      exp_grant_q.push_back(1'b1);
      cyc();
      rst = 1'b1; i_addr_vld = 1'b1;
      exp_grant_q.delete();
      ret_q.delete();
      @(negedge clk);
      check("rst2_m_addr_vld", 32'(m_addr_vld), 32'd0);
      check("rst2_rdy", {30'd0, i_addr_rdy, d_addr_rdy}, 32'd0);
      cyc();
      rst = 1'b0; d_addr_vld = 1'b0;
      exp_grant_q.push_back(1'b0);
      @(negedge clk);
      check("rst2_follow_vld", 32'(m_addr_vld), 32'd1);
      check("rst2_follow_i_rdy", 32'(i_addr_rdy), 32'd1);
      cyc();
      i_addr_vld = 1'b0; m_data_vld = 1'b1; m_rdata = 32'h9001;
      @(negedge clk);
      check("rst2_ret_i", 32'(i_data_vld), 32'd1);
      cyc();
      m_data_vld = 1'b0;
      cyc();

      check("grant_q_drained", 32'(exp_grant_q.size()), 32'd0);
      check("ret_q_drained", 32'(ret_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
